sq_circ_queue: RTL and testbench

- Parametrised circular store queue, successor to the shift-register store queue; sits between dispatch, the store/load execute units, ROB retire and the dcache write port.
- Head, commit and tail pointers with a wrap bit split the queue into two regions:
  - committed-not-drained: from head up to commit;
  - speculative: from commit up to tail.
- Adds a dcache valid/ready drain handshake, flush of speculative stores, and a per-byte load-forwarding stall.

---
 rtl/sq_pkg.sv | 47 ++++
 rtl/sq_fwd_byte_sel.sv | 21 ++
 rtl/sq_circ_queue.sv | 181 ++++++++++++++++++
 tb/tb_sq_circ_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// Shared types for the circular store queue: entry record, access size and
// the mask-to-size/offset decode used by the dcache drain port.
package sq_pkg;
  localparam int SQ_XLEN   = 32;
  localparam int SQ_PREG_W = 6;
  localparam logic [SQ_PREG_W-1:0] ZERO_PREG = '0;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MEM_SIZE;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [SQ_PREG_W-1:0] tag;
    logic [SQ_XLEN-3:0]   addr;
    logic [3:0]           mask;
    logic [SQ_XLEN-1:0]   data;
  } SQ_ENTRY;

  typedef struct packed {
    MEM_SIZE    size;
    logic [1:0] offset;
    logic       legal;
  } size_off_t;

  function automatic size_off_t mask_to_size_offset(input logic [3:0] mask);
    size_off_t r;
    r.size   = MEM_WORD;
    r.offset = 2'd0;
    r.legal  = 1'b1;
    case (mask)
      4'b0001: begin r.size = MEM_BYTE; r.offset = 2'd0; end
      4'b0010: begin r.size = MEM_BYTE; r.offset = 2'd1; end
      4'b0100: begin r.size = MEM_BYTE; r.offset = 2'd2; end
      4'b1000: begin r.size = MEM_BYTE; r.offset = 2'd3; end
      4'b0011: begin r.size = MEM_HALF; r.offset = 2'd0; end
      4'b0110: begin r.size = MEM_HALF; r.offset = 2'd1; end
      4'b1100: begin r.size = MEM_HALF; r.offset = 2'd2; end
      4'b1111: r.size = MEM_WORD;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/sq_fwd_byte_sel.sv
// One forwarding byte lane: picks the youngest hit from a candidate vector
// rotated so that position 0 is the queue head (oldest).
module sq_fwd_byte_sel #(
  parameter int N = 8
) (
  input  logic [N-1:0]      hit,
  input  logic [N-1:0][7:0] lane,
  output logic              sel,
  output logic [7:0]        lane_out
);
  always_comb begin
    sel      = 1'b0;
    lane_out = '0;
    for (int p = 0; p < N; p++) begin
      if (hit[p]) begin
        sel      = 1'b1;
        lane_out = lane[p];
      end
    end
  end
endmodule

// File: rtl/sq_circ_queue.sv
// Circular store queue with head/commit/tail pointers, dcache drain, flush and
// per-byte load forwarding. Define SQ_FWD_BYPASS_EN to forward same-cycle st_ex writes.
module sq_circ_queue
  import sq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int XLEN       = SQ_XLEN,
  parameter int PREG_W     = SQ_PREG_W
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [DISPATCH_W-1:0]               disp_valid,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]   disp_tag,
  output logic [$clog2(DEPTH+1)-1:0]          free_slots,
  input  logic                                st_ex_valid,
  input  logic [PREG_W-1:0]                   st_ex_tag,
  input  logic [XLEN-3:0]                     st_ex_addr,
  input  logic [3:0]                          st_ex_mask,
  input  logic [XLEN-1:0]                     st_ex_data,
  input  logic                                ld_valid,
  input  logic [XLEN-3:0]                     ld_addr,
  input  logic [PREG_W-1:0]                   ld_older_tag,
  output logic [3:0]                          fwd_mask,
  output logic [XLEN-1:0]                     fwd_data,
  output logic                                fwd_stall,
  input  logic [$clog2(RETIRE_W+1)-1:0]       retire_cnt,
  input  logic                                flush,
  output logic                                dc_req_valid,
  input  logic                                dc_req_ready,
  output logic [XLEN-1:0]                     dc_req_addr,
  output logic [1:0]                          dc_req_size,
  output logic [XLEN-1:0]                     dc_req_data,
  output logic                                empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NB    = XLEN / 8;

  SQ_ENTRY          ent [DEPTH];
  logic [PTR_W-1:0] head, commit, tail;
  logic [PTR_W-1:0] head_n, commit_n, tail_n, count, spec_cnt, spec_cnt_n, n_disp;
  logic [IDX_W-1:0] head_idx, commit_idx, tail_idx;
  logic [DEPTH-1:0] is_spec, flushed, ex_hit;
  logic             fire;
  SQ_ENTRY          h;
  size_off_t        so;

  assign head_idx   = head[IDX_W-1:0];
  assign commit_idx = commit[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign count      = tail - head;
  assign spec_cnt   = tail - commit;
  assign free_slots = CNT_W'(PTR_W'(DEPTH) - count);
  assign empty      = (head == tail);

  always_comb begin
    n_disp = '0;
    for (int k = 0; k < DISPATCH_W; k++) n_disp = n_disp + PTR_W'(disp_valid[k]);
  end

  assign fire       = dc_req_valid & dc_req_ready;
  assign commit_n   = commit + PTR_W'(retire_cnt);
  assign head_n     = head + PTR_W'(fire);
  assign tail_n     = flush ? commit_n : tail + n_disp;
  assign spec_cnt_n = tail - commit_n;

  // Region membership by distance from commit, before and after this cycle's retire.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [IDX_W-1:0] off_c, off_n;
    assign off_c      = IDX_W'(i) - commit_idx;
    assign off_n      = IDX_W'(i) - commit_n[IDX_W-1:0];
    assign is_spec[i] = ({1'b0, off_c} < spec_cnt);
    assign flushed[i] = flush && ({1'b0, off_n} < spec_cnt_n);
    assign ex_hit[i]  = st_ex_valid && ent[i].valid && is_spec[i] && !flushed[i]
                        && (ent[i].tag == st_ex_tag);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      commit <= '0;
      tail   <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      head   <= head_n;
      commit <= commit_n;
      tail   <= tail_n;
      for (int i = 0; i < DEPTH; i++) begin
        if (ex_hit[i]) begin
          ent[i].ready <= 1'b1;
          ent[i].addr  <= st_ex_addr;
          ent[i].mask  <= st_ex_mask;
          ent[i].data  <= st_ex_data;
        end
        if ((fire && head_idx == IDX_W'(i)) || flushed[i]) begin
          ent[i].valid <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end
      if (!flush) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (disp_valid[k]) begin
            ent[tail_idx + IDX_W'(k)].valid <= 1'b1;
            ent[tail_idx + IDX_W'(k)].ready <= 1'b0;
            ent[tail_idx + IDX_W'(k)].tag   <= disp_tag[k];
          end
        end
      end
    end
  end

  assign h            = ent[head_idx];
  assign so           = mask_to_size_offset(h.mask);
  assign dc_req_valid = (head != commit);
  assign dc_req_addr  = {h.addr, so.offset};
  assign dc_req_size  = so.size;
  assign dc_req_data  = h.data >> {so.offset, 3'b000};

  logic [DEPTH-1:0]           e_rdy;
  logic [XLEN-3:0]            e_addr [DEPTH];
  logic [3:0]                 e_mask [DEPTH];
  logic [XLEN-1:0]            e_data [DEPTH];
  logic [DEPTH-1:0]           tag_m, cand, rot_rdy, rot_match;
  logic [NB-1:0][DEPTH-1:0]   rot_hit;
  logic [NB-1:0][DEPTH-1:0][7:0] rot_byte;
  logic [NB-1:0]              fwd_sel;
  logic [NB-1:0][7:0]         fwd_lane;

  for (genvar i = 0; i < DEPTH; i++) begin : g_eff
`ifdef SQ_FWD_BYPASS_EN
    assign e_rdy[i]  = ent[i].ready | ex_hit[i];
    assign e_addr[i] = ex_hit[i] ? st_ex_addr : ent[i].addr;
    assign e_mask[i] = ex_hit[i] ? st_ex_mask : ent[i].mask;
    assign e_data[i] = ex_hit[i] ? st_ex_data : ent[i].data;
`else
    assign e_rdy[i]  = ent[i].ready;
    assign e_addr[i] = ent[i].addr;
    assign e_mask[i] = ent[i].mask;
    assign e_data[i] = ent[i].data;
`endif
  end

  // Position p is the p-th oldest live entry; candidates run up to the older-store tag.
  for (genvar p = 0; p < DEPTH; p++) begin : g_rot
    logic [IDX_W-1:0] pi;
    assign pi           = head_idx + IDX_W'(p);
    assign tag_m[p]     = (PTR_W'(p) < count) && ent[pi].valid && (ent[pi].tag == ld_older_tag);
    assign cand[p]      = ld_valid && (ld_older_tag != ZERO_PREG) && (|tag_m[DEPTH-1:p]);
    assign rot_rdy[p]   = e_rdy[pi];
    assign rot_match[p] = cand[p] && e_rdy[pi] && (e_addr[pi] == ld_addr);
    for (genvar j = 0; j < NB; j++) begin : g_lane
      assign rot_hit[j][p]  = rot_match[p] && e_mask[pi][j];
      assign rot_byte[j][p] = e_data[pi][8*j +: 8];
    end
  end

  sq_fwd_byte_sel #(.N(DEPTH)) u_sel [NB-1:0] (
    .hit      (rot_hit),
    .lane     (rot_byte),
    .sel      (fwd_sel),
    .lane_out (fwd_lane)
  );

  assign fwd_mask  = fwd_sel;
  assign fwd_data  = fwd_lane;
  assign fwd_stall = |(cand & ~rot_rdy);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert ((disp_valid & (disp_valid + 1'b1)) == '0);
      assert (n_disp <= PTR_W'(free_slots));
      assert (PTR_W'(retire_cnt) <= spec_cnt);
      for (int r = 0; r < RETIRE_W; r++)
        if (r < int'(retire_cnt)) assert (ent[commit_idx + IDX_W'(r)].ready);
      if (dc_req_valid) assert (so.legal);
    end
  end
endmodule

// File: tb/tb_sq_circ_queue.sv
// Scoreboard bench for sq_circ_queue: expected drain requests are queued at
// execute time and compared as the dcache port accepts them.
module tb_sq_circ_queue;
  logic             clock = 1'b0;
  logic             reset_n;
  logic [1:0]       disp_valid;
  logic [1:0][5:0]  disp_tag;
  logic [3:0]       free_slots;
  logic             st_ex_valid;
  logic [5:0]       st_ex_tag;
  logic [29:0]      st_ex_addr;
  logic [3:0]       st_ex_mask;
  logic [31:0]      st_ex_data;
  logic             ld_valid;
  logic [29:0]      ld_addr;
  logic [5:0]       ld_older_tag;
  logic [3:0]       fwd_mask;
  logic [31:0]      fwd_data;
  logic             fwd_stall;
  logic [1:0]       retire_cnt;
  logic             flush;
  logic             dc_req_valid, dc_req_ready;
  logic [31:0]      dc_req_addr, dc_req_data;
  logic [1:0]       dc_req_size;
  logic             empty;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } req_t;

  req_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   m_head = 0, m_commit = 0, m_tail = 0;

  always #5 clock = ~clock;

  sq_circ_queue dut (
    .clock(clock), .reset_n(reset_n), .disp_valid(disp_valid), .disp_tag(disp_tag),
    .free_slots(free_slots), .st_ex_valid(st_ex_valid), .st_ex_tag(st_ex_tag),
    .st_ex_addr(st_ex_addr), .st_ex_mask(st_ex_mask), .st_ex_data(st_ex_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_older_tag(ld_older_tag),
    .fwd_mask(fwd_mask), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .retire_cnt(retire_cnt), .flush(flush), .dc_req_valid(dc_req_valid),
    .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr), .dc_req_size(dc_req_size),
    .dc_req_data(dc_req_data), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic req_t exp_req(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
    req_t r;
    int pc = 0, lsb = 0, off;
    for (int j = 3; j >= 0; j--) if (m[j]) begin pc++; lsb = j; end
    off    = (pc == 4) ? 0 : lsb;
    r.size = (pc == 1) ? 2'd0 : (pc == 2) ? 2'd1 : 2'd2;
    r.addr = {a, 2'(off)};
    r.data = d >> (8 * off);
    return r;
  endfunction

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic disp(input int n, input logic [5:0] t0, input logic [5:0] t1);
    disp_valid = (n == 2) ? 2'b11 : 2'b01;
    disp_tag   = {t1, t0};
    tick;
    disp_valid = 2'b00;
    m_tail += n;
  endtask

  task automatic exec(input logic [5:0] t, input logic [29:0] a, input logic [3:0] m,
                      input logic [31:0] d, input bit push);
    st_ex_valid = 1'b1; st_ex_tag = t; st_ex_addr = a; st_ex_mask = m; st_ex_data = d;
    if (push) sb.push_back(exp_req(a, m, d));
    tick;
    st_ex_valid = 1'b0;
  endtask

  task automatic retire(input int n);
    retire_cnt = 2'(n);
    tick;
    retire_cnt = 2'd0;
    m_commit += n;
  endtask

  task automatic probe(input string tag, input logic [5:0] older, input logic [29:0] a,
                       input logic [3:0] em, input logic [31:0] ed, input logic es);
    ld_valid = 1'b1; ld_older_tag = older; ld_addr = a;
    #1;
    chk({tag, "_mask"}, fwd_mask, em);
    chk({tag, "_data"}, fwd_data, ed);
    chk({tag, "_stall"}, fwd_stall, es);
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int c = 0; c < 40 && !empty; c++) tick;
    chk(tag, empty, 1'b1);
  endtask

  task automatic chk_free(input string tag);
    chk(tag, free_slots, 4'(8 - (m_tail - m_head)));
  endtask

  // Drain monitor: the handshake seen at the falling edge completes on the next rising edge.
  initial begin
    req_t e;
    forever begin
      @(negedge clock);
      if (reset_n && dc_req_valid && dc_req_ready) begin
        chk("drain_sb", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("drain_addr", dc_req_addr, e.addr);
          chk("drain_size", dc_req_size, e.size);
          chk("drain_data", dc_req_data, e.data);
        end
        m_head++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  mlist [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1111};
    logic [29:0] a;
    logic [31:0] d;
    req_t        e40;
    reset_n = 1'b0; disp_valid = '0; disp_tag = '0; st_ex_valid = 1'b0; st_ex_tag = '0;
    st_ex_addr = '0; st_ex_mask = '0; st_ex_data = '0; ld_valid = 1'b0; ld_addr = '0;
    ld_older_tag = '0; retire_cnt = '0; flush = 1'b0; dc_req_ready = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    chk("rst_empty", empty, 1'b1);
    chk("rst_free", free_slots, 4'd8);
    chk("rst_dcv", dc_req_valid, 1'b0);
    chk("rst_fwd", {fwd_mask, fwd_stall}, 5'd0);

    // asynchronous reset with stores in flight
    disp(2, 6'd1, 6'd2);
    disp(1, 6'd7, 6'd0);
    exec(6'd1, 30'h5, 4'b1111, 32'hDEADBEEF, 1'b0);
    retire(1);
    chk("pre_rst_dcv", dc_req_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_free", free_slots, 4'd8);
    chk("arst_dcv", dc_req_valid, 1'b0);
    m_head = 0; m_commit = 0; m_tail = 0; sb.delete();
    tick;
    reset_n = 1'b1;
    tick;

    // dispatch, execute, drain
    dc_req_ready = 1'b1;
    disp(2, 6'd5, 6'd6);
    exec(6'd5, 30'h10, 4'b0010, 32'h0000AB00, 1'b1);
    retire(1);
    tick;
    chk("t1_head_eq_commit", dc_req_valid, 1'b0);
    chk_free("t1_free");
    exec(6'd6, 30'h11, 4'b1111, 32'hCAFEBABE, 1'b1);
    retire(1);
    wait_empty("t1_empty");

    // pointer wrap, one store per iteration
    for (int i = 0; i < 20; i++) begin
      a = 30'($urandom); d = $urandom;
      disp(1, 6'(10 + i), 6'd0);
      chk_free("wrap_free");
      exec(6'(10 + i), a, mlist[i % 8], d, 1'b1);
      retire(1);
    end
    wait_empty("wrap_empty");

    // fill to full, then drain in order
    for (int i = 0; i < 4; i++) disp(2, 6'(40 + 2*i), 6'(41 + 2*i));
    chk("full_free", free_slots, 4'd0);
    chk("full_empty", empty, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 30'($urandom); d = $urandom;
      exec(6'(40 + i), a, mlist[7 - i], d, 1'b1);
    end
    for (int i = 0; i < 4; i++) retire(2);
    wait_empty("full_drain_empty");

    // forwarding and backpressure
    dc_req_ready = 1'b0;
    disp(2, 6'd3, 6'd4);
    exec(6'd3, 30'h20, 4'b1111, 32'h11223344, 1'b1);
    ld_valid = 1'b1; ld_older_tag = 6'd4; ld_addr = 30'h20;
    #1 chk("fwd_unexec_stall", fwd_stall, 1'b1);
    ld_valid = 1'b0;
    probe("fwd_t3_pre", 6'd3, 30'h20, 4'hF, 32'h11223344, 1'b0);
    exec(6'd4, 30'h20, 4'b0001, 32'h00000055, 1'b1);
    probe("fwd_t4", 6'd4, 30'h20, 4'hF, 32'h11223355, 1'b0);
    probe("fwd_t3", 6'd3, 30'h20, 4'hF, 32'h11223344, 1'b0);
    probe("fwd_other_addr", 6'd4, 30'h21, 4'h0, 32'h0, 1'b0);
    probe("fwd_tag0", 6'd0, 30'h20, 4'h0, 32'h0, 1'b0);
    probe("fwd_notfound", 6'd9, 30'h20, 4'h0, 32'h0, 1'b0);
    ld_older_tag = 6'd4; ld_addr = 30'h20;
    #1 chk("fwd_ldv0", {fwd_mask, fwd_data, fwd_stall}, 37'd0);
    retire(2);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", dc_req_valid, 1'b1);
      chk("bp_addr", dc_req_addr, 32'h80);
      chk("bp_size", dc_req_size, 2'd2);
      chk("bp_data", dc_req_data, 32'h11223344);
      tick;
    end
    probe("bp_fwd", 6'd4, 30'h20, 4'hF, 32'h11223355, 1'b0);
    dc_req_ready = 1'b1;
    wait_empty("fwd_empty");

    // flush with a same-cycle retire, dispatch and execute
    dc_req_ready = 1'b0;
    disp(2, 6'd40, 6'd41);
    disp(2, 6'd42, 6'd43);
    disp(1, 6'd44, 6'd0);
    e40 = exp_req(30'h100, 4'b1111, 32'hA1B2C3D4);
    exec(6'd40, 30'h100, 4'b1111, 32'hA1B2C3D4, 1'b1);
    exec(6'd41, 30'h101, 4'b0110, 32'h00BEEF00, 1'b1);
    exec(6'd42, 30'h102, 4'b1000, 32'h77000000, 1'b1);
    retire(2);
    flush = 1'b1; retire_cnt = 2'd1;
    disp_valid = 2'b01; disp_tag = {6'd0, 6'd50};
    st_ex_valid = 1'b1; st_ex_tag = 6'd44; st_ex_addr = 30'h30; st_ex_mask = 4'hF; st_ex_data = 32'h1;
    tick;
    flush = 1'b0; retire_cnt = 2'd0; disp_valid = 2'b00; st_ex_valid = 1'b0;
    m_commit += 1; m_tail = m_commit;
    chk_free("flush_free");
    chk("flush_dcv", dc_req_valid, 1'b1);
    chk("flush_addr", dc_req_addr, e40.addr);
    chk("flush_size", dc_req_size, e40.size);
    chk("flush_data", dc_req_data, e40.data);
    probe("flush_t43", 6'd43, 30'h30, 4'h0, 32'h0, 1'b0);
    probe("flush_t44", 6'd44, 30'h30, 4'h0, 32'h0, 1'b0);
    probe("flush_t50", 6'd50, 30'h30, 4'h0, 32'h0, 1'b0);
    dc_req_ready = 1'b1;
    disp(1, 6'd45, 6'd0);
    exec(6'd45, 30'h103, 4'b0011, 32'h0000F00D, 1'b1);
    retire(1);
    wait_empty("flush_empty");
    chk("sb_left", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
